// File: rtl/wb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter_4
// Description : 4-master to 1-slave pipelined Wishbone round-robin arbiter
//               with a per-grant outstanding-strobe cap.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter_4 #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                wbm_cyc_i,
    input  logic [3:0]                wbm_stb_i,
    input  logic [3:0]                wbm_we_i,
    input  logic [4*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [4*DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic [4*SELECT_WIDTH-1:0] wbm_sel_i,
    output logic [DATA_WIDTH-1:0]     wbm_dat_o,
    output logic [3:0]                wbm_ack_o,
    output logic [3:0]                wbm_err_o,
    output logic [3:0]                wbm_stall_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic                      wbs_we_o,
    output logic [ADDR_WIDTH-1:0]     wbs_adr_o,
    output logic [DATA_WIDTH-1:0]     wbs_dat_o,
    output logic [SELECT_WIDTH-1:0]   wbs_sel_o,
    input  logic [DATA_WIDTH-1:0]     wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_stall_i,
    output logic [3:0]                grant_o
);

    localparam logic       STATE_IDLE = 1'b0;
    localparam logic       STATE_BUSY = 1'b1;
    localparam logic [3:0] CNT_MAX    = 4'(MAX_OUTSTANDING);

    logic       state_q, state_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic [3:0] outstanding_q, outstanding_d;

    logic       w_busy;
    logic       w_cyc_g;
    logic       w_cap;
    logic       w_fwd;
    logic       w_accept;
    logic       w_resp;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic [1:0] w_scan_idx;

    assign w_busy   = (state_q == STATE_BUSY);
    assign w_cyc_g  = wbm_cyc_i[grant_idx_q];
    assign w_cap    = (outstanding_q == CNT_MAX);
    // Responses only count while the granted master still holds its cycle.
    assign w_fwd    = w_busy & w_cyc_g & (outstanding_q != 4'd0);
    assign w_resp   = w_fwd & (wbs_ack_i | wbs_err_i);
    assign w_accept = wbs_stb_o & ~wbs_stall_i;

    // Scan from last_grant+4 (lowest priority) down to last_grant+1 so the
    // nearest requester above the previous winner is assigned last.
    always_comb begin
        w_pick_idx   = 2'd0;
        w_pick_valid = 1'b0;
        w_scan_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_scan_idx = last_grant_q + 2'(k);
            if (wbm_cyc_i[w_scan_idx]) begin
                w_pick_idx   = w_scan_idx;
                w_pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STATE_IDLE;
            grant_idx_q   <= 2'd0;
            last_grant_q  <= 2'd3;
            outstanding_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            grant_idx_q   <= grant_idx_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx_q;
        last_grant_d  = last_grant_q;
        outstanding_d = outstanding_q;
        case (state_q)
            STATE_IDLE: begin
                outstanding_d = 4'd0;
                if (w_pick_valid) begin
                    state_d     = STATE_BUSY;
                    grant_idx_d = w_pick_idx;
                end
            end
            STATE_BUSY: begin
                if (!w_cyc_g) begin
                    state_d       = STATE_IDLE;
                    last_grant_d  = grant_idx_q;
                    outstanding_d = 4'd0;
                end else if (w_accept && !w_resp) begin
                    outstanding_d = outstanding_q + 4'd1;
                end else if (w_resp && !w_accept) begin
                    outstanding_d = outstanding_q - 4'd1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_comb begin
        wbs_cyc_o   = 1'b0;
        wbs_stb_o   = 1'b0;
        grant_o     = 4'b0000;
        wbm_stall_o = 4'b1111;
        wbm_ack_o   = 4'b0000;
        wbm_err_o   = 4'b0000;
        if (w_busy) begin
            wbs_cyc_o                = w_cyc_g;
            wbs_stb_o                = wbm_stb_i[grant_idx_q] & ~w_cap;
            grant_o[grant_idx_q]     = 1'b1;
            wbm_stall_o[grant_idx_q] = wbs_stall_i | w_cap;
            wbm_ack_o[grant_idx_q]   = wbs_ack_i & w_fwd;
            wbm_err_o[grant_idx_q]   = wbs_err_i & w_fwd;
        end
    end

    assign wbs_we_o  = wbm_we_i[grant_idx_q];
    assign wbs_adr_o = wbm_adr_i[grant_idx_q*ADDR_WIDTH +: ADDR_WIDTH];
    assign wbs_dat_o = wbm_dat_i[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign wbs_sel_o = wbm_sel_i[grant_idx_q*SELECT_WIDTH +: SELECT_WIDTH];
    assign wbm_dat_o = wbs_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_rr_arbiter_4
// Description : Self-checking bench for wb_rr_arbiter_4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter_4;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      wbm_cyc_i, wbm_stb_i, wbm_we_i;
    logic [4*AW-1:0] wbm_adr_i;
    logic [4*DW-1:0] wbm_dat_i;
    logic [4*SW-1:0] wbm_sel_i;
    logic [DW-1:0]   wbm_dat_o;
    logic [3:0]      wbm_ack_o, wbm_err_o, wbm_stall_o;
    logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [SW-1:0]   wbs_sel_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i, wbs_err_i, wbs_stall_i;
    logic [3:0]      grant_o;

    wb_rr_arbiter_4 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_stall_o(wbm_stall_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_stall_i(wbs_stall_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t       vecs[10];
    logic [3:0] sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         acc_cnt;
    logic [3:0] exp_g;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wbm_cyc_i = 4'b0; wbm_stb_i = 4'b0;
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_stall_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_grant"}, 64'(grant_o), 64'h0);
        chk({tag, "_stall"}, 64'(wbm_stall_o), 64'hF);
        chk({tag, "_cyc"}, 64'(wbs_cyc_o), 64'h0);
        chk({tag, "_stb"}, 64'(wbs_stb_o), 64'h0);
        chk({tag, "_err"}, 64'(wbm_err_o), 64'h0);
    endtask

    initial begin
        // Round-robin rounds from reset (last_grant=3), hand-derived winners.
        vecs[0] = '{4'b0101, 2'd0};
        vecs[1] = '{4'b0101, 2'd2};
        vecs[2] = '{4'b0101, 2'd0};
        vecs[3] = '{4'b1000, 2'd3};
        vecs[4] = '{4'b1111, 2'd0};
        vecs[5] = '{4'b1111, 2'd1};
        vecs[6] = '{4'b0001, 2'd0};
        vecs[7] = '{4'b0110, 2'd1};
        vecs[8] = '{4'b1001, 2'd3};
        vecs[9] = '{4'b0010, 2'd1};

        wbm_we_i  = 4'b1010;
        wbm_adr_i = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        wbm_dat_i = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        wbm_sel_i = 16'hF731;
        wbs_dat_i = 32'hDEAD_BEEF;
        do_reset();
        chk_idle_outputs("reset");
        chk("reset_ack", 64'(wbm_ack_o), 64'h0);
        chk("dat_bcast", 64'(wbm_dat_o), 64'hDEAD_BEEF);

        for (int i = 0; i < 10; i++) begin
            wbm_cyc_i = vecs[i].req;
            sb_q.push_back(4'b0001 << vecs[i].exp_idx);
            #1;
            chk("decide_grant", 64'(grant_o), 64'h0);
            chk("decide_stall", 64'(wbm_stall_o), 64'hF);
            step();
            exp_g = sb_q.pop_front();
            chk("tbl_grant", 64'(grant_o), 64'(exp_g));
            chk("tbl_adr", 64'(wbs_adr_o), 64'(32'hA000_0000 + 32'(vecs[i].exp_idx)));
            chk("tbl_sel", 64'(wbs_sel_o), 64'(4'(16'hF731 >> (4 * vecs[i].exp_idx))));
            wbm_cyc_i = 4'b0;
            step();
            chk("tbl_release", 64'(grant_o), 64'h0);
        end

        // Masters 0 and 2 together, m0 drops cyc.
        do_reset();
        wbm_cyc_i = 4'b0101; wbm_stb_i = 4'b0101;
        #1;
        chk("m02_decide_stb", 64'(wbs_stb_o), 64'h0);
        step();
        chk("m02_first", 64'(grant_o), 64'b0001);
        wbm_cyc_i = 4'b0100; wbm_stb_i = 4'b0100;
        step();
        chk("m02_gap", 64'(grant_o), 64'h0);
        step();
        chk("m02_second", 64'(grant_o), 64'b0100);

        // All four request continuously, one access each.
        do_reset();
        wbm_cyc_i = 4'b1111; wbm_stb_i = 4'b0;
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back(4'b0001 << (k % 4));
            step();
            exp_g = sb_q.pop_front();
            chk("rr_grant", 64'(grant_o), 64'(exp_g));
            wbm_stb_i = exp_g;
            #1;
            chk("rr_stb", 64'(wbs_stb_o), 64'h1);
            step();
            wbm_stb_i = 4'b0; wbs_ack_i = 1'b1;
            #1;
            chk("rr_ack", 64'(wbm_ack_o), 64'(exp_g));
            step();
            wbs_ack_i = 1'b0;
            wbm_cyc_i = wbm_cyc_i & ~exp_g;
            step();
            wbm_cyc_i = 4'b1111;
        end

        // Outstanding cap on master 1.
        do_reset();
        wbm_cyc_i = 4'b0010;
        step();
        chk("cap_grant", 64'(grant_o), 64'b0010);
        wbm_stb_i = 4'b0010;
        #1;
        acc_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            acc_cnt += int'(wbs_stb_o & ~wbs_stall_i);
            step();
        end
        chk("cap_accepted", 64'(acc_cnt), 64'd4);
        chk("cap_stall", 64'(wbm_stall_o[1]), 64'h1);
        chk("cap_stb", 64'(wbs_stb_o), 64'h0);
        wbs_ack_i = 1'b1;
        #1;
        chk("cap_ack", 64'(wbm_ack_o), 64'b0010);
        step();
        wbs_ack_i = 1'b0;
        #1;
        acc_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            acc_cnt += int'(wbs_stb_o & ~wbs_stall_i);
            step();
        end
        chk("cap_one_more", 64'(acc_cnt), 64'd1);

        // Error on the 2nd of 3 pipelined reads.
        do_reset();
        wbm_cyc_i = 4'b0100;
        step();
        chk("err_grant", 64'(grant_o), 64'b0100);
        wbm_stb_i = 4'b0100;
        repeat (3) step();
        wbm_stb_i = 4'b0; wbs_dat_i = 32'h1111_2222; wbs_ack_i = 1'b1;
        #1;
        chk("err_r1_ack", 64'(wbm_ack_o), 64'b0100);
        chk("err_r1_dat", 64'(wbm_dat_o), 64'h1111_2222);
        step();
        wbs_ack_i = 1'b0; wbs_err_i = 1'b1;
        #1;
        chk("err_r2_err", 64'(wbm_err_o), 64'b0100);
        chk("err_r2_ack", 64'(wbm_ack_o), 64'h0);
        step();
        wbs_err_i = 1'b0; wbs_ack_i = 1'b1;
        #1;
        chk("err_r3_ack", 64'(wbm_ack_o), 64'b0100);
        chk("err_r3_err", 64'(wbm_err_o), 64'h0);
        step();
        chk("err_drained", 64'(wbm_ack_o), 64'h0);
        wbs_ack_i = 1'b0; wbm_cyc_i = 4'b0;
        step();

        // Abandoned transfer with 2 outstanding, then late acks.
        do_reset();
        wbm_cyc_i = 4'b1001;
        step();
        chk("abn_grant0", 64'(grant_o), 64'b0001);
        wbm_stb_i = 4'b0001;
        repeat (2) step();
        wbm_stb_i = 4'b0; wbm_cyc_i = 4'b1000; wbs_ack_i = 1'b1;
        #1;
        chk("abn_release_ack", 64'(wbm_ack_o), 64'h0);
        step();
        chk("abn_idle_grant", 64'(grant_o), 64'h0);
        chk("abn_idle_ack", 64'(wbm_ack_o), 64'h0);
        step();
        chk("abn_grant3", 64'(grant_o), 64'b1000);
        chk("abn_unsolicited", 64'(wbm_ack_o), 64'h0);
        wbs_ack_i = 1'b0; wbm_stb_i = 4'b1000;
        #1;
        chk("abn_stb3", 64'(wbs_stb_o), 64'h1);
        chk("abn_stall3", 64'(wbm_stall_o), 64'b0111);
        step();
        wbm_stb_i = 4'b0; wbs_ack_i = 1'b1;
        #1;
        chk("abn_ack3", 64'(wbm_ack_o), 64'b1000);
        wbs_ack_i = 1'b0; wbm_cyc_i = 4'b0;
        step();

        // Reset while busy with 3 outstanding.
        do_reset();
        wbm_cyc_i = 4'b0010;
        step();
        chk("rstb_grant", 64'(grant_o), 64'b0010);
        wbm_stb_i = 4'b0010;
        repeat (3) step();
        wbm_stb_i = 4'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_outputs("rstb");
        wbs_ack_i = 1'b1;
        #1;
        chk("rstb_idle_ack", 64'(wbm_ack_o), 64'h0);
        step();
        chk("rstb_regrant", 64'(grant_o), 64'b0010);
        chk("rstb_late_ack", 64'(wbm_ack_o), 64'h0);
        wbs_ack_i = 1'b0; wbm_cyc_i = 4'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter_4.md
WB_RR_ARBITER_4 -- requirements
Module: wb_rr_arbiter_4

Interface -- parameters
REQ-001 DATA_WIDTH, 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 ADDR_WIDTH, 32, address bus width in bits.
REQ-003 SELECT_WIDTH, DATA_WIDTH/8, byte select width.
REQ-004 MAX_OUTSTANDING, 4, maximum accepted-but-unacknowledged strobes per grant (1..15).

Interface -- ports (wbm_* are flattened 4-master arrays; master n occupies slice n)
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wbm_cyc_i  input  4  per-master cycle request.
REQ-008 wbm_stb_i  input  4  per-master strobe.
REQ-009 wbm_we_i  input  4  per-master write enable.
REQ-010 wbm_adr_i  input  4*ADDR_WIDTH  per-master address.
REQ-011 wbm_dat_i  input  4*DATA_WIDTH  per-master write data.
REQ-012 wbm_sel_i  input  4*SELECT_WIDTH  per-master byte select.
REQ-013 wbm_dat_o  output  DATA_WIDTH  read data, broadcast to all masters.
REQ-014 wbm_ack_o, wbm_err_o, wbm_stall_o  output  4 each  per-master ack, err and stall.
REQ-015 wbs_cyc_o, wbs_stb_o, wbs_we_o  output  1 each; wbs_adr_o ADDR_WIDTH; wbs_dat_o DATA_WIDTH; wbs_sel_o SELECT_WIDTH  slave request.
REQ-016 wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_stall_i  input  DATA_WIDTH/1/1/1  slave response.
REQ-017 grant_o  output  4  one-hot current grant (debug/perf); 0 when idle.

Function
REQ-018 The FSM SHALL have two states: IDLE and BUSY.
REQ-019 In IDLE with any wbm_cyc_i set, the block SHALL enter BUSY next cycle, granting the first requester found scanning upward (wrapping) from last_grant+1.
  - Request-to-grant latency: exactly 1 cycle.
  - No wbs_stb_o and no wbm_stall_o deassertion in the decision cycle.
REQ-020 In IDLE, wbs_cyc_o, wbs_stb_o, grant_o SHALL be 0 and wbm_stall_o SHALL be 4'b1111.
REQ-021 In BUSY, wbs_cyc_o SHALL equal wbm_cyc_i[g] and wbs_stb_o SHALL equal wbm_stb_i[g] & ~cap, where g is the granted index and cap = (outstanding == MAX_OUTSTANDING).
  - wbs_adr_o/dat_o/sel_o/we_o SHALL carry slice g combinationally.
REQ-022 wbm_stall_o[g] SHALL be wbs_stall_i | cap; every non-granted bit SHALL be 1.
REQ-023 wbm_ack_o[g]/wbm_err_o[g] SHALL be wbs_ack_i/wbs_err_i while BUSY and outstanding != 0; non-granted bits and all bits in IDLE SHALL be 0.
  - Unsolicited slave ack (outstanding == 0) SHALL be dropped.
REQ-024 Outstanding counter: +1 on wbs_stb_o & ~wbs_stall_i, -1 on (wbs_ack_i | wbs_err_i) with outstanding != 0; a simultaneous accept and response SHALL leave it unchanged.
  - It SHALL never exceed MAX_OUTSTANDING or underflow.
REQ-025 BUSY SHALL return to IDLE when wbm_cyc_i[g] is 0.
  - last_grant <= g, outstanding <= 0, including abandoned transfers with outstanding != 0.
  - A response arriving in the release cycle SHALL not be forwarded.
REQ-026 A granted master SHALL never be preempted while its cyc is held; other requests wait.
REQ-027 After release, the IDLE decision SHALL rotate priority so a continuously requesting master waits at most 3 grants.
REQ-028 wbm_dat_o SHALL equal wbs_dat_i at all times.

Reset
REQ-029 With rst high at a clock edge, the block SHALL enter IDLE next cycle with outstanding=0, last_grant=3 (so master 0 wins first), grant_o=0, wbs_cyc_o=0, wbs_stb_o=0, wbm_ack_o=0, wbm_err_o=0, wbm_stall_o=4'b1111.
REQ-030 Reset asserted mid-BUSY SHALL abandon the transfer; pending slave responses after reset SHALL be dropped per REQ-023.

Verification
REQ-031 After reset, cyc/stb on masters 0 and 2 together -> grant_o=0001 after 1 cycle; after m0 drops cyc, grant_o=0000 for 1 cycle, then 0100.
REQ-032 All 4 masters request continuously, each releasing after 1 access -> grant order 0,1,2,3,0, no master skipped.
REQ-033 With MAX_OUTSTANDING=4, master 1 issues 6 strobes, slave never acks -> 4 accepted, then wbm_stall_o[1]=1 and wbs_stb_o=0; one ack -> exactly one more accepted.
REQ-034 Slave err on the 2nd of 3 pipelined reads -> wbm_err_o[g] pulses 1 cycle, other acks forwarded, outstanding returns to 0.
REQ-035 Master drops cyc with 2 outstanding, then slave acks -> acks not forwarded, next requester granted with outstanding=0.
REQ-036 rst pulsed while BUSY with 3 outstanding -> IDLE next cycle, all outputs at REQ-029 values, late slave ack dropped.
